// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment display scanner.
// Each digit slot is PRESCALE+1 clocks long. It starts with BLANK_CYCLES of
// blanking and then lights one digit. The glyph and decimal point are latched
// when the slot lights. Every output is a flop, so reset darkens the display
// at once and no combinational path runs from the inputs to the pins.
module seg7_scan #(
    parameter int          DIGITS       = 4,
    parameter logic [23:0] PRESCALE     = 24'd29999,
    parameter int          BLANK_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dpIn,
    output logic [6:0]            segN,
    output logic                  dpN,
    output logic [DIGITS-1:0]     digitN,
    output logic [2:0]            scanIdx
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [23:0]       BLANK_END = 24'(BLANK_CYCLES - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DIGIT0    = {{(DIGITS-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [23:0]       presc_q, presc_d;
    logic [2:0]        idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] dig_q, dig_d;

    logic              tick;
    logic              blank_done;

    // The nibble and dp tables are padded to eight entries. This lets the
    // 3-bit slot index address them directly for any DIGITS value.
    logic [3:0] nib [8];
    logic       dp_ext [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            if (gi < DIGITS) begin : g_used
                assign nib[gi]    = data[4*gi +: 4];
                assign dp_ext[gi] = dpIn[gi];
            end else begin : g_pad
                assign nib[gi]    = 4'h0;
                assign dp_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // Active-high hex glyphs, with bit0 = a through bit6 = g.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return p;
    endfunction

    assign tick       = (presc_q == PRESCALE);
    assign blank_done = (presc_q == BLANK_END);

    // Compute the next state and the next value of each registered output.
    // Outputs are dark unless the next state is SHOW.
    always_comb begin
        state_d = state_q;
        presc_d = tick ? 24'd0 : presc_q + 24'd1;
        idx_d   = idx_q;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        dig_d   = '1;
        if (!enable) begin
            // Disable wins over everything else, including a tick in the same cycle.
            state_d = ST_OFF;
            presc_d = 24'd0;
            idx_d   = 3'd0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    presc_d = 24'd0;
                    idx_d   = 3'd0;
                end
                ST_BLANK: begin
                    if (blank_done) begin
                        // Latch the glyph and dp of this slot when it lights.
                        state_d = ST_SHOW;
                        seg_d   = ~hex7(nib[idx_q]);
                        dp_d    = ~dp_ext[idx_q];
                        dig_d   = ~(DIGIT0 << idx_q);
                    end
                end
                ST_SHOW: begin
                    if (tick) begin
                        // The slot ends. Go dark before the next digit is
                        // driven, so two digit lines are never low together.
                        state_d = ST_BLANK;
                        idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                    end else begin
                        seg_d = seg_q;
                        dp_d  = dp_q;
                        dig_d = dig_q;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    presc_d = 24'd0;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    // State, prescaler and output registers. Reset clears them at once,
    // without waiting for a clock edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_OFF;
            presc_q <= 24'd0;
            idx_q   <= 3'd0;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            dig_q   <= '1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
        end
    end

    assign segN    = seg_q;
    assign dpN     = dp_q;
    assign digitN  = dig_q;
    assign scanIdx = idx_q;

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The module SHALL have parameter DIGITS, default 4, giving the number of multiplexed digits (2..8).
REQ-002 The module SHALL have parameter PRESCALE, default 24'd29999, giving the scan tick period minus one in clk cycles (400 Hz at 12 MHz).
REQ-003 The module SHALL have parameter BLANK_CYCLES, default 255, giving the inter-digit blanking length in clk cycles, legal range 1..PRESCALE-1.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The module SHALL have port rstN, input, 1 bit: the asynchronous active-low reset.
REQ-006 The module SHALL have port enable, input, 1 bit: high = scan running, low = display dark.
REQ-007 The module SHALL have port data, input, 4*DIGITS bits: hex nibble per digit, with digit i at data[4i+3:4i].
REQ-008 The module SHALL have port dpIn, input, DIGITS bits: decimal point request per digit, 1 = lit.
REQ-009 The module SHALL have port segN, output, 7 bits: active-low segments, bit0=a .. bit6=g.
REQ-010 The module SHALL have port dpN, output, 1 bit: active-low decimal point.
REQ-011 The module SHALL have port digitN, output, DIGITS bits: active-low digit select, one-hot-low or all high.
REQ-012 The module SHALL have port scanIdx, output, 3 bits: index of the current or next digit slot.

Function
REQ-013 The block SHALL contain a 24-bit prescaler counting 0..PRESCALE, wrapping to 0, and asserting an internal tick in the cycle where count==PRESCALE.
REQ-014 The block SHALL implement three states: OFF (all dark), BLANK (all digitN high, segN=7'h7F, dpN=1) and SHOW (one digit driven).
REQ-015 In OFF with enable=1, the block SHALL, on the next clock, enter BLANK with scanIdx=0 and the prescaler at 0.
REQ-016 BLANK SHALL last exactly BLANK_CYCLES cycles, then the block SHALL enter SHOW.
REQ-017 On SHOW entry, the block SHALL snapshot data nibble and dpIn bit of scanIdx; later changes to data are not visible until the next slot.
REQ-018 In SHOW, digitN[scanIdx] SHALL be 0 with all other bits 1, segN SHALL be the inverse of the decode pattern, and dpN SHALL be the inverse of the snapshot dp.
REQ-019 Active-high decode SHALL be: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-020 On a tick in SHOW, the block SHALL, on the next clock, enter BLANK with scanIdx incremented, wrapping from DIGITS-1 to 0.
REQ-021 Each digit slot SHALL span PRESCALE+1 cycles: BLANK_CYCLES dark, then PRESCALE+1-BLANK_CYCLES lit.
REQ-022 All outputs SHALL be registered; no combinational path from data or enable to the outputs.
REQ-023 enable=0 in any state SHALL, on the next clock, force OFF: outputs dark, scanIdx=0, prescaler held at 0.
REQ-024 enable=0 SHALL take priority over a coincident tick.
REQ-025 digitN SHALL never have more than one bit low in any cycle, including state transitions.

Reset
REQ-026 rstN=0 SHALL asynchronously force state=OFF, prescaler=0, scanIdx=0, segN=7'h7F, dpN=1, and digitN all ones.
REQ-027 After rstN release, the first active edge SHALL behave as in OFF (REQ-015 / REQ-023).
REQ-028 A reset asserted mid-SHOW SHALL darken all outputs immediately, without waiting for a clock edge.

Verification (PRESCALE=9, BLANK_CYCLES=2, DIGITS=4)
REQ-029 Reset, then enable=1 with data=16'h4321 -> 2 dark cycles, then digitN=4'b1110 and segN=~7'h06 for 8 cycles, then 2 dark cycles, then digitN=4'b1101 and segN=~7'h5B.
REQ-030 Run 40+ cycles -> scanIdx sequence is 0,1,2,3,0, and each slot is 10 cycles long.
REQ-031 Change data[3:0] from 1 to 8 mid-SHOW of digit 0 -> segN stays ~7'h06 until the slot ends; the next digit-0 slot shows ~7'h7F.
REQ-032 dpIn=4'b0100 -> dpN=0 only while digitN=4'b1011.
REQ-033 Drop enable in SHOW, coincident with a tick -> next cycle all dark, scanIdx=0; re-raise enable -> digit 0 follows after 2 blank cycles.
REQ-034 Assert rstN=0 mid-SHOW between clock edges -> digitN=all ones immediately; the checker flags any cycle with two or more digitN bits low.
